// File: rtl/stack_alu_ctrl.sv
// Data-stack controller for the 16-bit Forth core: owns T, keeps N and below in a RAM,
// and sequences an external combinational ALU for two-operand and literal operations.
//
// state | meaning
// IDLE  | accepting commands; single-cycle ops complete here
// READ  | RAM read of N in flight
// EXEC  | Nq valid; DROP/SWAP/ALU2 update T and the stack
module stack_alu_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_funct,
  input  logic [WIDTH-1:0] cmd_lit,
  output logic [WIDTH-1:0] alu_t,
  output logic [WIDTH-1:0] alu_y,
  output logic [4:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flagz,
  output logic [WIDTH-1:0] tos,
  output logic [AW:0]      depth,
  output logic             zero_flag,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic             busy
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_DROP   = 3'b010;
  localparam logic [2:0] OP_DUP    = 3'b011;
  localparam logic [2:0] OP_SWAP   = 3'b100;
  localparam logic [2:0] OP_ALU2   = 3'b101;
  localparam logic [2:0] OP_ALUL   = 3'b110;
  localparam logic [2:0] OP_CLRERR = 3'b111;

  localparam logic [AW:0] D_ONE  = (AW+1)'(1);
  localparam logic [AW:0] D_TWO  = (AW+1)'(2);
  localparam logic [AW:0] D_FULL = (AW+1)'(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] nq_q;
  logic [AW:0]      depth_q;
  logic [2:0]       op_q;
  logic [4:0]       funct_q;
  logic             zf_q;
  logic             err_un_q;
  logic             err_ov_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             is_full;
  logic             is_empty;
  logic [AW-1:0]    sp;
  logic [AW-1:0]    sp_m1;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign is_full  = (depth_q == D_FULL);
  assign is_empty = (depth_q == '0);
  // sp/sp-1 are only used when they are in range, so truncation is safe
  assign sp       = AW'(depth_q - D_ONE);
  assign sp_m1    = AW'(depth_q - D_TWO);

  always_comb begin
    alu_y     = cmd_lit;
    alu_funct = cmd_funct;
    if (state_q == S_EXEC && op_q == OP_ALU2) begin
      alu_y     = nq_q;
      alu_funct = funct_q;
    end
    mem_we    = 1'b0;
    mem_waddr = sp;
    mem_wdata = t_q;
    if (!reset) begin
      if (accept && cmd_op == OP_PUSH && !is_full && !is_empty) mem_we = 1'b1;
      if (accept && cmd_op == OP_DUP && !is_full && !is_empty) mem_we = 1'b1;
      if (state_q == S_EXEC && op_q == OP_SWAP) begin
        mem_we    = 1'b1;
        mem_waddr = sp_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state_q == S_READ) nq_q <= mem[sp_m1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      depth_q  <= '0;
      op_q     <= OP_NOP;
      funct_q  <= '0;
      zf_q     <= 1'b0;
      err_un_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q    <= cmd_op;
          funct_q <= cmd_funct;
          case (cmd_op)
            OP_PUSH:
              if (is_full) err_ov_q <= 1'b1;
              else begin
                t_q     <= cmd_lit;
                depth_q <= depth_q + D_ONE;
              end
            OP_DROP:
              if (is_empty) err_un_q <= 1'b1;
              else if (depth_q == D_ONE) begin
                t_q     <= '0;
                depth_q <= '0;
              end else state_q <= S_READ;
            OP_DUP:
              if (is_empty) err_un_q <= 1'b1;
              else if (is_full) err_ov_q <= 1'b1;
              else depth_q <= depth_q + D_ONE;
            OP_SWAP, OP_ALU2:
              if (depth_q < D_TWO) err_un_q <= 1'b1;
              else state_q <= S_READ;
            OP_ALUL:
              if (is_empty) err_un_q <= 1'b1;
              else begin
                t_q  <= alu_result;
                zf_q <= alu_flagz;
              end
            OP_CLRERR: begin
              err_un_q <= 1'b0;
              err_ov_q <= 1'b0;
            end
            default: ;
          endcase
        end
        S_READ: state_q <= S_EXEC;
        S_EXEC: begin
          state_q <= S_IDLE;
          case (op_q)
            OP_DROP: begin
              t_q     <= nq_q;
              depth_q <= depth_q - D_ONE;
            end
            OP_SWAP: t_q <= nq_q;
            OP_ALU2: begin
              t_q     <= alu_result;
              zf_q    <= alu_flagz;
              depth_q <= depth_q - D_ONE;
            end
            default: ;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign alu_t         = t_q;
  assign tos           = t_q;
  assign depth         = depth_q;
  assign zero_flag     = zf_q;
  assign err_underflow = err_un_q;
  assign err_overflow  = err_ov_q;

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// Directed bench for stack_alu_ctrl with a small behavioural ALU on the side.
module tb_stack_alu_ctrl;

  localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_DROP = 3'd2, OP_DUP = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4, OP_ALU2 = 3'd5, OP_ALUL = 3'd6, OP_CLRERR = 3'd7;
  localparam logic [4:0] F_ADD = 5'b00000, F_AND = 5'b00100, F_SUB = 5'b01000, F_NSUB = 5'b11000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = OP_NOP;
  logic [4:0]  cmd_funct = '0;
  logic [15:0] cmd_lit = '0;
  logic [15:0] alu_t, alu_y, alu_result, tos;
  logic [4:0]  alu_funct;
  logic        alu_flagz;
  logic [4:0]  depth;
  logic        zero_flag, err_underflow, err_overflow, busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  stack_alu_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_funct(cmd_funct), .cmd_lit(cmd_lit),
    .alu_t(alu_t), .alu_y(alu_y), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_flagz(alu_flagz),
    .tos(tos), .depth(depth), .zero_flag(zero_flag),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .busy(busy)
  );

  always_comb begin
    case (alu_funct)
      F_ADD:   alu_result = alu_t + alu_y;
      F_AND:   alu_result = alu_t & alu_y;
      F_SUB:   alu_result = alu_t - alu_y;
      F_NSUB:  alu_result = alu_y - alu_t;
      default: alu_result = alu_t;
    endcase
  end
  assign alu_flagz = (alu_result == 16'h0000);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive one command for exactly one accepting edge, then return 1ns after it
  task automatic send(input logic [2:0] op, input logic [4:0] funct, input logic [15:0] lit);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_funct = funct;
    cmd_lit   = lit;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) check_val("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic alu2_latency(input logic [4:0] funct, input string tag);
    int low = 0;
    send(OP_ALU2, funct, 16'h0);
    for (int i = 0; i < 10 && !cmd_ready; i++) begin
      @(negedge clk);
      if (!cmd_ready) low++;
    end
    check_val({tag, "_ready_low"}, 32'(low), 32'd2);
  endtask

  initial begin
    // reset state
    #12;
    check_val("rst_tos", 32'(tos), 32'h0);
    check_val("rst_depth", 32'(depth), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // N - T and T - N
    send(OP_PUSH, 5'd0, 16'd5);
    send(OP_PUSH, 5'd0, 16'd3);
    check_val("push_depth", 32'(depth), 32'd2);
    alu2_latency(F_NSUB, "nsub");
    check_val("nsub_tos", 32'(tos), 32'h0002);
    check_val("nsub_depth", 32'(depth), 32'd1);
    check_val("nsub_zf", 32'(zero_flag), 32'd0);
    do_reset();
    send(OP_PUSH, 5'd0, 16'd5);
    send(OP_PUSH, 5'd0, 16'd3);
    alu2_latency(F_SUB, "sub");
    check_val("sub_tos", 32'(tos), 32'hFFFE);
    check_val("sub_depth", 32'(depth), 32'd1);

    // underflow and clear
    do_reset();
    send(OP_DROP, 5'd0, 16'd0);
    check_val("uf_drop_flag", 32'(err_underflow), 32'd1);
    check_val("uf_drop_depth", 32'(depth), 32'd0);
    check_val("uf_drop_ready", 32'(cmd_ready), 32'd1);
    send(OP_ALU2, F_ADD, 16'd0);
    check_val("uf_alu2_flag", 32'(err_underflow), 32'd1);
    check_val("uf_alu2_ready", 32'(cmd_ready), 32'd1);
    send(OP_CLRERR, 5'd0, 16'd0);
    check_val("clrerr_uf", 32'(err_underflow), 32'd0);
    send(OP_DUP, 5'd0, 16'd0);
    check_val("uf_dup_flag", 32'(err_underflow), 32'd1);
    send(OP_CLRERR, 5'd0, 16'd0);

    // fill to DEPTH+1, overflow, drain
    do_reset();
    for (int i = 1; i <= 17; i++) send(OP_PUSH, 5'd0, 16'(i));
    check_val("full_depth", 32'(depth), 32'd17);
    check_val("full_tos", 32'(tos), 32'd17);
    send(OP_PUSH, 5'd0, 16'd18);
    check_val("ovf_flag", 32'(err_overflow), 32'd1);
    check_val("ovf_tos", 32'(tos), 32'd17);
    check_val("ovf_depth", 32'(depth), 32'd17);
    send(OP_DUP, 5'd0, 16'd0);
    check_val("ovf_dup_depth", 32'(depth), 32'd17);
    send(OP_DROP, 5'd0, 16'd0);
    wait_idle();
    check_val("drain1_tos", 32'(tos), 32'd16);
    for (int i = 0; i < 15; i++) begin
      send(OP_DROP, 5'd0, 16'd0);
      wait_idle();
    end
    check_val("drain_tos", 32'(tos), 32'd1);
    check_val("drain_depth", 32'(depth), 32'd1);
    check_val("drain_ovf_sticky", 32'(err_overflow), 32'd1);

    // swap
    do_reset();
    send(OP_PUSH, 5'd0, 16'hAAAA);
    send(OP_PUSH, 5'd0, 16'h5555);
    send(OP_SWAP, 5'd0, 16'd0);
    wait_idle();
    check_val("swap_tos", 32'(tos), 32'hAAAA);
    check_val("swap_depth", 32'(depth), 32'd2);
    send(OP_DROP, 5'd0, 16'd0);
    wait_idle();
    check_val("swap_drop_tos", 32'(tos), 32'h5555);
    check_val("swap_drop_depth", 32'(depth), 32'd1);

    // literal ALU op, single cycle
    do_reset();
    send(OP_PUSH, 5'd0, 16'h00FF);
    send(OP_ALUL, F_AND, 16'hFF00);
    check_val("alul_tos", 32'(tos), 32'h0000);
    check_val("alul_zf", 32'(zero_flag), 32'd1);
    check_val("alul_depth", 32'(depth), 32'd1);
    check_val("alul_busy", 32'(busy), 32'd0);
    check_val("alul_ready", 32'(cmd_ready), 32'd1);

    // DUP then T + N
    send(OP_PUSH, 5'd0, 16'h1234);
    send(OP_DUP, 5'd0, 16'd0);
    check_val("dup_depth", 32'(depth), 32'd3);
    send(OP_ALU2, F_ADD, 16'd0);
    wait_idle();
    check_val("dup_add_tos", 32'(tos), 32'h2468);
    check_val("dup_add_zf", 32'(zero_flag), 32'd0);
    send(OP_DROP, 5'd0, 16'd0);
    wait_idle();
    check_val("dup_drop_tos", 32'(tos), 32'h0000);

    // async reset mid-command
    do_reset();
    send(OP_PUSH, 5'd0, 16'd7);
    send(OP_PUSH, 5'd0, 16'd9);
    send(OP_ALU2, F_ADD, 16'd0);
    check_val("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_val("mid_busy", 32'(busy), 32'd0);
    check_val("mid_depth", 32'(depth), 32'd0);
    check_val("mid_tos", 32'(tos), 32'd0);
    check_val("mid_errs", 32'({err_underflow, err_overflow}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(OP_PUSH, 5'd0, 16'd4);
    check_val("post_rst_tos", 32'(tos), 32'd4);
    check_val("post_rst_depth", 32'(depth), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/stack_alu_ctrl.md
Name: stack_alu_ctrl

Overview:
- Data-stack controller for the 16-bit Forth core. Owns the top-of-stack register T and a RAM-backed second-stack (N and below).
- Accepts stack/arithmetic commands over a valid/ready handshake and sequences the external combinational ALU: drives operands and funct, captures Result into T.
- Sits between the instruction decoder and the ALU. Flags stack underflow and overflow.

Parameters:
WIDTH, 16, data cell width in bits.
DEPTH, 16, entries in stack RAM (below T); maximum stack depth is DEPTH+1.
AW, 4, RAM address width, clog2(DEPTH).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command this cycle.
cmd_op  in  3  000 NOP, 001 PUSH, 010 DROP, 011 DUP, 100 SWAP, 101 ALU2, 110 ALUL, 111 CLRERR.
cmd_funct  in  5  ALU function code, used by ALU2/ALUL.
cmd_lit  in  WIDTH  literal, used by PUSH/ALUL.
alu_t  out  WIDTH  ALU operand 1, always equal to T.
alu_y  out  WIDTH  ALU operand 2.
alu_funct  out  5  ALU function select.
alu_result  in  WIDTH  ALU result, combinational.
alu_flagz  in  1  ALU zero flag.
tos  out  WIDTH  current T.
depth  out  AW+1  number of valid cells including T (0..DEPTH+1).
zero_flag  out  1  alu_flagz captured at the last ALU2/ALUL completion.
err_underflow  out  1  sticky underflow error.
err_overflow  out  1  sticky overflow error.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async):
  - state=IDLE; T=0, depth=0, sp=0, zero_flag=0, both errors=0, latched op/funct=0.
  - RAM contents are not cleared.
  - Reset during READ/EXEC aborts the command and makes no RAM write.
- Storage: mem[0..DEPTH-1]; sp = depth-1 when depth≥1, else 0; N = mem[sp-1].
- Handshake:
  - A command is accepted when cmd_valid and cmd_ready are both high at a rising clk edge.
  - cmd_ready = (state==IDLE).
- FSM:
  - IDLE→READ on accepting DROP with depth≥2, SWAP, or ALU2 with no error.
  - READ→EXEC unconditionally; EXEC→IDLE unconditionally.
  - All other commands, and all erroring commands, complete at the accept edge and stay in IDLE (throughput 1/cycle).
- READ: RAM read at address sp-1; registered data (Nq) is valid in EXEC. cmd_op and cmd_funct are latched at acceptance.
- Single-cycle commands:
  - NOP: no effect.
  - PUSH: overflow if depth==DEPTH+1. Else, if depth≥1: mem[sp]=T, sp++. Then T=cmd_lit, depth++.
  - DUP: underflow if depth==0; overflow if full. Else mem[sp]=T, sp++, depth++.
  - DROP with depth==1: T=0, depth=0.
  - ALUL: underflow if depth==0. Else alu_y=cmd_lit, alu_funct=cmd_funct; T=alu_result, zero_flag=alu_flagz; depth unchanged.
  - CLRERR: both error flags cleared; nothing else changes.
- Multi-cycle commands, EXEC actions:
  - DROP: T=Nq, sp--, depth--.
  - SWAP: T=Nq, mem[sp-1]=old T; depth unchanged.
  - ALU2: alu_y=Nq, alu_funct=latched funct; T=alu_result, zero_flag=alu_flagz, sp--, depth--.
- Errors:
  - DROP with depth==0 → underflow. SWAP or ALU2 with depth<2 → underflow.
  - An erroring command leaves stack state, T and zero_flag unchanged, sets its sticky flag, and completes in one cycle.
  - Error flags are cleared only by CLRERR or reset.
- ALU drive outside EXEC/ALUL: alu_y=cmd_lit, alu_funct=cmd_funct (don't-care to consumers).
- Operand order: ALU2 computes f(T, N). Forth "a b -" (N−T) is issued with funct NSUB (11000); SUB (01000) gives T−N.
- Arithmetic: Result is passed through unmodified, including MULT/DIV codes. There is no carry or width extension; divide-by-zero is not checked.
- Latency:
  - PUSH/DUP/ALUL/NOP/CLRERR: result visible on tos/depth the cycle after acceptance.
  - DROP (depth≥2)/SWAP/ALU2: visible 3 cycles after acceptance; cmd_ready low for 2 cycles.

Test Plan:
- Reset; PUSH 5; PUSH 3; ALU2 funct=11000 → tos=0x0002, depth=1, zero_flag=0; cmd_ready low exactly 2 cycles; repeat with funct=01000 → tos=0xFFFE.
- Reset; DROP → err_underflow=1, depth=0, cmd_ready stays high; ALU2 → still 1; CLRERR → err_underflow=0.
- DEPTH=16: PUSH 1..17 → depth=17, tos=17; PUSH 18 → err_overflow=1, tos=17, depth=17; then 16 DROPs → tos=1, depth=1.
- PUSH 0xAAAA; PUSH 0x5555; SWAP → tos=0xAAAA, depth=2; DROP → tos=0x5555, depth=1.
- PUSH 0x00FF; ALUL funct=00100 lit=0xFF00 → tos=0x0000, zero_flag=1, depth=1, completes in 1 cycle, busy never high.
- PUSH 7; PUSH 9; ALU2; assert reset during READ → busy=0, depth=0, tos=0, errors=0 immediately (async); a following PUSH 4 gives tos=4, depth=1.
